sdram_arbiter: RTL and testbench

Three-port arbiter that shares the single SDRAM controller (Avalon-MM slave) between PlayCore, RecordCore and an auxiliary requester (loader/erase). Each requester uses a level-held read/write request with a one-cycle finished pulse. The arbiter serialises requests round-robin and runs one SDRAM transaction at a time. It sits between the audio cores and the SDRAM controller instance.

---
 rtl/sdram_arbiter_if.sv | 47 ++++
 rtl/sdram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Bus bundles around sdram_arbiter: the three-requester request bus and the
// Avalon-MM master bus toward the SDRAM controller.

interface sdram_req_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [2:0]             req_read;
  logic [2:0]             req_write;
  logic [2:0][ADDR_W-1:0] req_addr;
  logic [2:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]      req_readdata;
  logic [2:0]             req_finished;

  // master = the audio cores / aux loader, slave = the arbiter
  modport master (
    output req_read, req_write, req_addr, req_writedata,
    input  req_readdata, req_finished
  );
  modport slave (
    input  req_read, req_write, req_addr, req_writedata,
    output req_readdata, req_finished
  );
endinterface

interface avalon_mm_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] sdram_address;
  logic              sdram_read;
  logic              sdram_write;
  logic [DATA_W-1:0] sdram_writedata;
  logic [DATA_W-1:0] sdram_readdata;
  logic              sdram_readdatavalid;
  logic              sdram_waitrequest;

  // master = the arbiter, slave = the SDRAM controller
  modport master (
    output sdram_address, sdram_read, sdram_write, sdram_writedata,
    input  sdram_readdata, sdram_readdatavalid, sdram_waitrequest
  );
  modport slave (
    input  sdram_address, sdram_read, sdram_write, sdram_writedata,
    output sdram_readdata, sdram_readdatavalid, sdram_waitrequest
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM controller among play, record and aux.
// Optional read-data watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.

module sdram_arbiter #(
  parameter int         ADDR_W      = 23,
  parameter int         DATA_W      = 32,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sdram_req_if.slave         req,
  avalon_mm_if.master        sdram,
  output logic               arb_timeout,
  output logic [1:0]         debug
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_ISSUE     = 2'b01,
    S_WAIT_DATA = 2'b10,
    S_DONE      = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        grant_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_write_q;
  logic [DATA_W-1:0] rdata_q;

  logic [2:0]        pending;
  logic              found;
  logic [1:0]        pick;
  logic              timeout_hit;

  // Candidate index base+k, wrapped into 0..2 (base <= 2, k <= 3).
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

  // Search last+1, last+2, last so the most recently served port goes last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    pending = req.req_read | req.req_write;
    found   = 1'b0;
    pick    = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      if (!found && pending[rr_index(last_q, k)]) begin
        found = 1'b1;
        pick  = rr_index(last_q, k);
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timeout_q;

  assign timeout_hit = (state == S_WAIT_DATA) && !sdram.sdram_readdatavalid
                       && (wd_cnt == TIMEOUT_CYC - 8'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == S_ISSUE)
        wd_cnt <= 8'd0;
      else if (state == S_WAIT_DATA)
        wd_cnt <= wd_cnt + 8'd1;
    end
  end

  assign arb_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (found) state_nxt = S_ISSUE;
      S_ISSUE:     if (!sdram.sdram_waitrequest)
                     state_nxt = op_write_q ? S_DONE : S_WAIT_DATA;
      S_WAIT_DATA: if (sdram.sdram_readdatavalid || timeout_hit)
                     state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Transaction latch: once granted, the request lines no longer matter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_q    <= 2'd0;
      last_q     <= 2'd2;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (state == S_IDLE && found) begin
        grant_q    <= pick;
        last_q     <= pick;
        addr_q     <= req.req_addr[pick];
        wdata_q    <= req.req_writedata[pick];
        op_write_q <= req.req_write[pick];
      end
      if (state == S_WAIT_DATA) begin
        if (sdram.sdram_readdatavalid) rdata_q <= sdram.sdram_readdata;
        else if (timeout_hit)          rdata_q <= '0;
      end
    end
  end

  assign sdram.sdram_address   = addr_q;
  assign sdram.sdram_writedata = wdata_q;
  assign sdram.sdram_read      = (state == S_ISSUE) && !op_write_q;
  assign sdram.sdram_write     = (state == S_ISSUE) &&  op_write_q;

  assign req.req_readdata = rdata_q;
  assign req.req_finished = (state == S_DONE) ? (3'b001 << grant_q) : 3'b000;

  assign debug = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the timeout scenario follows
// whichever SDRAM_ARB_TIMEOUT_EN setting the design is built with.

module tb_sdram_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  logic i_clk = 1'b0;
  logic i_rst;
  logic arb_timeout;
  logic [1:0] debug;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_bus ();
  avalon_mm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) av_bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(8'd255)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .req         (req_bus.slave),
    .sdram       (av_bus.master),
    .arb_timeout (arb_timeout),
    .debug       (debug)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_bus.req_read           = 3'b000;
    req_bus.req_write          = 3'b000;
    req_bus.req_addr           = '0;
    req_bus.req_writedata      = '0;
    av_bus.sdram_readdata      = '0;
    av_bus.sdram_readdatavalid = 1'b0;
    av_bus.sdram_waitrequest   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({debug, av_bus.sdram_read, av_bus.sdram_write, req_bus.req_finished, arb_timeout} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got debug=%b rd=%b wr=%b fin=%b to=%b, want all 0",
               debug, av_bus.sdram_read, av_bus.sdram_write, req_bus.req_finished, arb_timeout);
    end
    n_checks++;
    if ({av_bus.sdram_address, av_bus.sdram_writedata, req_bus.req_readdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, want 0",
               av_bus.sdram_address, av_bus.sdram_writedata, req_bus.req_readdata);
    end
  endtask

  task automatic test_single_read();
    // cycle 0
    req_bus.req_read[0] = 1'b1;
    req_bus.req_addr[0] = 23'h000010;
    step(); // cycle 1
    n_checks++;
    if (debug !== 2'b01 || av_bus.sdram_read !== 1'b1 || av_bus.sdram_address !== 23'h000010) begin
      n_fail++;
      $display("FAIL rd_issue: got st=%b rd=%b addr=%h, want 01 1 000010",
               debug, av_bus.sdram_read, av_bus.sdram_address);
    end
    step(); // cycle 2
    n_checks++;
    if (debug !== 2'b10 || av_bus.sdram_read !== 1'b0 || req_bus.req_finished !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_wait: got st=%b rd=%b fin=%b, want 10 0 000",
               debug, av_bus.sdram_read, req_bus.req_finished);
    end
    av_bus.sdram_readdata      = 32'hDEADBEEF;
    av_bus.sdram_readdatavalid = 1'b1;
    step(); // cycle 3
    n_checks++;
    if (req_bus.req_finished !== 3'b001 || req_bus.req_readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_done: got fin=%b rdata=%h, want 001 deadbeef",
               req_bus.req_finished, req_bus.req_readdata);
    end
    req_bus.req_read[0]        = 1'b0;
    av_bus.sdram_readdatavalid = 1'b0;
    av_bus.sdram_readdata      = 32'h0BAD0BAD;
    step(); // back in IDLE
    n_checks++;
    if (debug !== 2'b00 || req_bus.req_finished !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_idle: got st=%b fin=%b, want 00 000", debug, req_bus.req_finished);
    end
  endtask

  task automatic test_write_wait();
    av_bus.sdram_waitrequest   = 1'b1;
    av_bus.sdram_readdatavalid = 1'b1; // outside WAIT_DATA, must be ignored
    req_bus.req_write[1]       = 1'b1;
    req_bus.req_addr[1]        = 23'h7FFFFF;
    req_bus.req_writedata[1]   = 32'h12345678;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) av_bus.sdram_waitrequest = 1'b0;
      n_checks++;
      if (av_bus.sdram_write !== 1'b1 || av_bus.sdram_read !== 1'b0 ||
          av_bus.sdram_address !== 23'h7FFFFF || av_bus.sdram_writedata !== 32'h12345678 ||
          req_bus.req_finished !== 3'b000) begin
        n_fail++;
        $display("FAIL wr_hold c%0d: got wr=%b rd=%b addr=%h wd=%h fin=%b, want 1 0 7fffff 12345678 000",
                 c, av_bus.sdram_write, av_bus.sdram_read, av_bus.sdram_address,
                 av_bus.sdram_writedata, req_bus.req_finished);
      end
    end
    step(); // cycle 4
    n_checks++;
    if (req_bus.req_finished !== 3'b010 || av_bus.sdram_write !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: got fin=%b wr=%b, want 010 0", req_bus.req_finished, av_bus.sdram_write);
    end
    n_checks++;
    if (req_bus.req_readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_keeps_rdata: got %h, want deadbeef", req_bus.req_readdata);
    end
    req_bus.req_write[1]       = 1'b0;
    av_bus.sdram_readdatavalid = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int fin_cyc;
    int to_pulses;
    req_bus.req_read[0] = 1'b1;
    req_bus.req_addr[0] = 23'h000123;
    step(); // cycle 1, ISSUE
    step(); // cycle 2, first WAIT_DATA
    n_checks++;
    if (debug !== 2'b10) begin
      n_fail++;
      $display("FAIL to_enter_wait: got st=%b, want 10", debug);
    end
`ifdef SDRAM_ARB_TIMEOUT_EN
    fin_cyc = -1;
    to_pulses = 0;
    for (int c = 3; c <= 300 && fin_cyc < 0; c++) begin
      step();
      if (arb_timeout === 1'b1) to_pulses++;
      if (req_bus.req_finished !== 3'b000) fin_cyc = c;
    end
    n_checks++;
    if (fin_cyc !== 257) begin
      n_fail++;
      $display("FAIL to_cycle: finished at cycle %0d, want 257", fin_cyc);
    end
    n_checks++;
    if (arb_timeout !== 1'b1 || to_pulses !== 1 || req_bus.req_finished !== 3'b001 ||
        req_bus.req_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_done: got to=%b pulses=%0d fin=%b rdata=%h, want 1 1 001 0",
               arb_timeout, to_pulses, req_bus.req_finished, req_bus.req_readdata);
    end
    req_bus.req_read[0] = 1'b0;
    step();
    n_checks++;
    if (arb_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_one_cycle: got to=%b, want 0", arb_timeout);
    end
`else
    fin_cyc = 0;
    to_pulses = 0;
    for (int c = 3; c <= 300; c++) begin
      step();
      if (arb_timeout !== 1'b0) to_pulses++;
      if (req_bus.req_finished !== 3'b000) fin_cyc++;
    end
    n_checks++;
    if (debug !== 2'b10 || fin_cyc !== 0 || to_pulses !== 0) begin
      n_fail++;
      $display("FAIL no_to_stuck: got st=%b fins=%0d to_pulses=%0d, want 10 0 0",
               debug, fin_cyc, to_pulses);
    end
    n_checks++;
    if (req_bus.req_readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL no_to_rdata: got %h, want deadbeef", req_bus.req_readdata);
    end
`endif
  endtask

  task automatic test_read_write_same();
    do_reset();
    req_bus.req_read[2]      = 1'b1;
    req_bus.req_write[2]     = 1'b1;
    req_bus.req_addr[2]      = 23'h2AAAAA;
    req_bus.req_writedata[2] = 32'hCAFEF00D;
    step(); // cycle 1
    n_checks++;
    if (av_bus.sdram_write !== 1'b1 || av_bus.sdram_read !== 1'b0 ||
        av_bus.sdram_address !== 23'h2AAAAA || av_bus.sdram_writedata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL rw_prec: got wr=%b rd=%b addr=%h wd=%h, want 1 0 2aaaaa cafef00d",
               av_bus.sdram_write, av_bus.sdram_read, av_bus.sdram_address, av_bus.sdram_writedata);
    end
    req_bus.req_read[2]  = 1'b0;
    req_bus.req_write[2] = 1'b0; // dropped early, transaction must still finish
    step(); // cycle 2
    n_checks++;
    if (req_bus.req_finished !== 3'b100 || av_bus.sdram_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_done: got fin=%b rd=%b, want 100 0", req_bus.req_finished, av_bus.sdram_read);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got [6];
    logic [2:0] want [6];
    int n;
    want = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) got[i] = 3'b000;
    do_reset();
    req_bus.req_read           = 3'b111;
    av_bus.sdram_readdatavalid = 1'b1;
    av_bus.sdram_readdata      = 32'h00C0FFEE;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      step();
      if (req_bus.req_finished !== 3'b000) begin
        got[n] = req_bus.req_finished;
        n++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got fin=%b, want %b", i, got[i], want[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_bus.req_read[0] = 1'b1;
    req_bus.req_addr[0] = 23'h000055;
    req_bus.req_addr[1] = 23'h000066;
    step();
    req_bus.req_read[1] = 1'b1;
    step(); // WAIT_DATA
    n_checks++;
    if (debug !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got st=%b, want 10", debug);
    end
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if ({debug, av_bus.sdram_read, av_bus.sdram_write, req_bus.req_finished, arb_timeout} !== 8'd0 ||
        av_bus.sdram_address !== '0 || req_bus.req_readdata !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got st=%b rd=%b wr=%b fin=%b to=%b addr=%h rdata=%h, want all 0",
               debug, av_bus.sdram_read, av_bus.sdram_write, req_bus.req_finished, arb_timeout,
               av_bus.sdram_address, req_bus.req_readdata);
    end
    av_bus.sdram_readdatavalid = 1'b1;
    step();
    n_checks++;
    if (req_bus.req_finished !== 3'b000 || debug !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_held: got fin=%b st=%b, want 000 00", req_bus.req_finished, debug);
    end
    av_bus.sdram_readdatavalid = 1'b0;
    i_rst = 1'b0;
    step();
    n_checks++;
    if (av_bus.sdram_read !== 1'b1 || av_bus.sdram_address !== 23'h000055) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: got rd=%b addr=%h, want 1 000055",
               av_bus.sdram_read, av_bus.sdram_address);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_wait();
    test_timeout();
    test_read_write_same();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
